// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN front-end blocks.
//   - default pixel width and frame geometry
//   - window-generator state encoding
//   - window element indexing helper and a small max helper
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FRAME_H        = 24;
    localparam int FRAME_W        = 24;
    localparam int WIN_F          = 5;
    localparam int WIN_ELEMS      = WIN_F * WIN_F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Flat element index of window element (r,c) in an f x f window.
    function automatic int win_idx(input int r, input int c, input int f);
        return r * f + c;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One-row pixel delay: a DEPTH-entry memory read and written at the same
// address. The read is combinational so the value stored one row earlier is
// available in the same cycle the new pixel overwrites it.
// Ports:
//   clk   - clock
//   en    - write enable (pixel accepted)
//   addr  - column address, shared by read and write
//   din   - pixel to store
//   dout  - pixel stored at addr one row earlier
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH      = FRAME_W,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/image_window_gen.sv
// -----------------------------------------------------------------------------
// image_window_gen
// Streaming F x F sliding-window generator. Pops one pixel per cycle from a
// first-word-fall-through FIFO, keeps F-1 line buffers plus an F x F window
// register, and presents every complete window in raster order on a
// valid/ready handshake. Pulses o_frame_done after the last window of a frame.
// Ports:
//   clk, resetn   - clock, asynchronous active-low reset
//   i_start       - frame start pulse (only honoured when idle)
//   i_empty       - pixel FIFO empty
//   i_rdata       - FIFO head pixel
//   o_ren         - FIFO pop / pixel accepted this cycle
//   o_window      - window, element (r,c) at [(r*F+c)*DATA_WIDTH +: DATA_WIDTH],
//                   r=0 oldest row, c=0 leftmost column
//   o_valid       - o_window holds a valid window
//   i_ready       - consumer accepts window when o_valid && i_ready
//   o_frame_done  - one-cycle pulse after the final window handshake
// Optional (macro WIN_POS_EN):
//   o_row, o_col  - top-left coordinate of the window in o_window
// -----------------------------------------------------------------------------
module image_window_gen
    import cnn_pkg::*;
#(
    parameter  int H          = FRAME_H,
    parameter  int W          = FRAME_W,
    parameter  int F          = WIN_F,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int POS_W      = $clog2(max_int(H, W))
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      i_start,
    input  logic                      i_empty,
    input  logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      o_ren,
    output logic [F*F*DATA_WIDTH-1:0] o_window,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_frame_done
`ifdef WIN_POS_EN
    ,
    output logic [POS_W-1:0]          o_row,
    output logic [POS_W-1:0]          o_col
`endif
);

    localparam int               LB_AW  = $clog2(W);
    localparam logic [POS_W-1:0] W_LAST = POS_W'(W - 1);
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H - 1);
    localparam logic [POS_W-1:0] F_LAST = POS_W'(F - 1);

    state_t                state;
    logic [POS_W-1:0]      row;
    logic [POS_W-1:0]      col;
    logic                  last_taken;
    logic                  accept;
    logic                  qualify;
    logic                  handshake;

    logic [DATA_WIDTH-1:0] lb_out [F-1];   // index 0 = oldest row
    logic [DATA_WIDTH-1:0] col_in [F];     // new right-hand window column
    logic [DATA_WIDTH-1:0] win_p0 [F][F];

    // Pop only while running, with a pixel available, before the frame's
    // last pixel, and when the window register is free or being drained.
    assign o_ren     = (state == S_RUN) && !i_empty && !last_taken && (!o_valid || i_ready);
    assign accept    = o_ren;
    assign qualify   = accept && (row >= F_LAST) && (col >= F_LAST);
    assign handshake = o_valid && i_ready;

    // Line-buffer chain: newest buffer stores the incoming pixel, each older
    // buffer stores what its newer neighbour just read out.
    for (genvar k = 0; k < F - 1; k++) begin : g_lb
        logic [DATA_WIDTH-1:0] din;
        if (k == F - 2) begin : g_newest
            assign din = i_rdata;
        end else begin : g_older
            assign din = lb_out[k + 1];
        end
        line_buffer #(
            .DEPTH      (W),
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (LB_AW)
        ) u_lb (
            .clk  (clk),
            .en   (accept),
            .addr (col[LB_AW-1:0]),
            .din  (din),
            .dout (lb_out[k])
        );
        assign col_in[k] = lb_out[k];
    end
    assign col_in[F-1] = i_rdata;

    // Stage p0: window shift register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F - 1; c++) begin
                    win_p0[r][c] <= win_p0[r][c + 1];
                end
                win_p0[r][F-1] <= col_in[r];
            end
        end
    end

    for (genvar r = 0; r < F; r++) begin : g_pack_r
        for (genvar c = 0; c < F; c++) begin : g_pack_c
            assign o_window[win_idx(r, c, F)*DATA_WIDTH +: DATA_WIDTH] = win_p0[r][c];
        end
    end

    // Control FSM, raster counters and registered handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            row          <= '0;
            col          <= '0;
            last_taken   <= 1'b0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_frame_done <= 1'b0;
                    if (i_start) begin
                        state      <= S_RUN;
                        row        <= '0;
                        col        <= '0;
                        last_taken <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col == W_LAST) begin
                            col <= '0;
                            if (row == H_LAST) begin
                                row        <= '0;
                                last_taken <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    // A fresh qualifying window wins over clearing on handshake.
                    if (qualify) begin
                        o_valid <= 1'b1;
                    end else if (handshake) begin
                        o_valid <= 1'b0;
                    end
                    // Once the last pixel is in, the pending window is the last one.
                    if (handshake && last_taken) begin
                        state        <= S_DONE;
                        o_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    o_frame_done <= 1'b0;
                    last_taken   <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    o_frame_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef WIN_POS_EN
    // Stage p0: window position, updated together with the window contents
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_row <= '0;
            o_col <= '0;
        end else if (qualify) begin
            o_row <= row - F_LAST;
            o_col <= col - F_LAST;
        end
    end
`endif

endmodule

// File: tb/tb_image_window_gen.sv
// -----------------------------------------------------------------------------
// tb_image_window_gen
// Directed bench for image_window_gen with default geometry (24x24, F=5).
// Pixel (r,c) = (r*24+c) & 0xFF, optionally inverted for a second frame.
// -----------------------------------------------------------------------------
module tb_image_window_gen;

    localparam int H    = 24;
    localparam int W    = 24;
    localparam int F    = 5;
    localparam int DW   = 8;
    localparam int NPIX = H * W;
    localparam int WPR  = W - F + 1;
    localparam int NWIN = (H - F + 1) * (W - F + 1);
    localparam int WB   = F * F * DW;
    localparam int PW   = $clog2(H > W ? H : W);

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_start;
    logic          i_empty;
    logic [DW-1:0] i_rdata;
    logic          o_ren;
    logic [WB-1:0] o_window;
    logic          o_valid;
    logic          i_ready;
    logic          o_frame_done;
`ifdef WIN_POS_EN
    logic [PW-1:0] o_row;
    logic [PW-1:0] o_col;
`endif

    image_window_gen #(
        .H          (H),
        .W          (W),
        .F          (F),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_empty      (i_empty),
        .i_rdata      (i_rdata),
        .o_ren        (o_ren),
        .o_window     (o_window),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_done (o_frame_done)
`ifdef WIN_POS_EN
        ,
        .o_row        (o_row),
        .o_col        (o_col)
`endif
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int pidx    = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    int cyc     = 0;
    int last_hs = -10;
    bit inv_g   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (window %0d, pixel %0d)", tag, got, exp, win_cnt, pidx);
        end
    endtask

    function automatic logic [DW-1:0] pix_idx(input int idx, input bit inv);
        logic [DW-1:0] v;
        v = idx[DW-1:0];
        return inv ? ~v : v;
    endfunction

    function automatic logic [WB-1:0] exp_window(input int k, input bit inv);
        logic [WB-1:0] ew;
        int wr;
        int wc;
        wr = k / WPR;
        wc = k % WPR;
        ew = '0;
        for (int i = 0; i < F; i++) begin
            for (int j = 0; j < F; j++) begin
                ew[(i*F+j)*DW +: DW] = pix_idx((wr + i) * W + (wc + j), inv);
            end
        end
        return ew;
    endfunction

    // One clock: observe at the falling edge, advance the FIFO model on the
    // rising edge, then return 1 time unit later for the next drive.
    task automatic step();
        bit ren_s;
        @(negedge clk);
        ren_s = o_ren;
        if (o_frame_done) begin
            done_cnt++;
            check("done_after_last", cyc, last_hs + 1);
            check("done_wins", win_cnt, NWIN);
        end
        if (o_valid && i_ready) begin
            if (win_cnt == 0) begin
                check("first_pidx", pidx, 101);
                check("first_e00", o_window[0 +: DW], inv_g ? 8'hFF : 8'h00);
                check("first_e44", o_window[24*DW +: DW], inv_g ? 8'h9B : 8'h64);
            end
            check("window", o_window == exp_window(win_cnt, inv_g), 1'b1);
`ifdef WIN_POS_EN
            check("win_row", o_row, win_cnt / WPR);
            check("win_col", o_col, win_cnt % WPR);
`endif
            win_cnt++;
            last_hs = cyc;
        end
        @(posedge clk);
        cyc++;
        if (ren_s) pidx++;
        #1;
    endtask

    task automatic run_frame(input bit inv, input bit gap, input bit stall,
                             input bit start_mid, input int abort_at, input int tail);
        int            stall_left;
        bit            stalled;
        logic [WB-1:0] saved;
        pidx       = 0;
        win_cnt    = 0;
        done_cnt   = 0;
        inv_g      = inv;
        stall_left = 0;
        stalled    = 1'b0;
        saved      = '0;
        i_empty    = 1'b1;
        i_ready    = 1'b1;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
        for (int budget = 0; budget < 4000 && done_cnt == 0; budget++) begin
            if (abort_at > 0 && pidx >= abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_ren", o_ren, 1'b0);
                check("abort_valid", o_valid, 1'b0);
                check("abort_window", |o_window, 1'b0);
                check("abort_done", o_frame_done, 1'b0);
                @(posedge clk);
                #1;
                resetn  = 1'b1;
                i_empty = 1'b1;
                return;
            end
            i_start = start_mid && (pidx == 150);
            if (stall && !stalled && o_valid && win_cnt == 50) begin
                stalled    = 1'b1;
                stall_left = 10;
                saved      = o_window;
            end
            i_ready = (stall_left == 0);
            i_empty = (pidx >= NPIX) || (gap && (cyc % 3 == 0));
            i_rdata = (pidx < NPIX) ? pix_idx(pidx, inv) : '0;
            if (stall_left > 0) begin
                #1;
                check("stall_ren", o_ren, 1'b0);
                check("stall_valid", o_valid, 1'b1);
                check("stall_window", o_window == saved, 1'b1);
                stall_left--;
            end
            step();
        end
        i_start = 1'b0;
        i_empty = 1'b1;
        i_ready = 1'b1;
        repeat (tail) step();
        check("win_count", win_cnt, NWIN);
        check("done_count", done_cnt, 1);
        check("idle_ren", o_ren, 1'b0);
        if (stall) check("stall_seen", stalled, 1'b1);
    endtask

    initial begin
        resetn  = 1'b0;
        i_start = 1'b0;
        i_empty = 1'b1;
        i_ready = 1'b1;
        i_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ren", o_ren, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_window", |o_window, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        // start while running must not restart the frame
        i_start = 1'b0;

        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0,   3);   // gapless reference
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0,   2);   // consumer stall
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0,   2);   // FIFO gaps
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 0,   3);   // stray start mid-frame
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 200, 0);   // reset mid-frame
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0,   2);   // clean frame after abort
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0,   0);   // back-to-back pair
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 0,   2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
